// File: rtl/fft_butterfly_sequencer_pkg.sv
// fft_pkg: shared types and default parameters for the FFT butterfly sequencer
package fft_pkg;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;
  localparam int LOG2_N_DEF = 10;
  localparam int MEM_RD_LATENCY_DEF = 1;
  localparam int CU_LATENCY_DEF = 14;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_e;
endpackage

// File: rtl/fft_butterfly_sequencer_if.sv
// fft_butterfly_sequencer_if: control/address bundle between sequencer and RAM/ROM/compute unit
// master: sequencer side (takes start, drives strobes, addresses, stage, busy, done)
// slave : controller/memory side
// FFT_SEQ_INVERSE_EN adds inverse (to sequencer) and tw_conj (from sequencer)
interface fft_butterfly_sequencer_if import fft_pkg::*; #(parameter int LOG2_N = LOG2_N_DEF);
  localparam int SW = $clog2(LOG2_N);
  logic start, busy, done, rd_en, wr_en;
  logic [LOG2_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2_N-2:0] tw_addr;
  logic [SW-1:0] stage;
`ifdef FFT_SEQ_INVERSE_EN
  logic inverse, tw_conj;
`endif
  modport master (
`ifdef FFT_SEQ_INVERSE_EN
    input inverse, output tw_conj,
`endif
    input start, output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    wr_en, wr_addr_a, wr_addr_b, stage
  );
  modport slave (
`ifdef FFT_SEQ_INVERSE_EN
    output inverse, input tw_conj,
`endif
    output start, input busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    wr_en, wr_addr_a, wr_addr_b, stage
  );
endinterface

// File: rtl/fft_butterfly_sequencer_delay_line.sv
// fft_seq_delay_line: DEPTH-stage shift register, q is d delayed exactly DEPTH cycles
// Ports: clk, areset (async clear), d (input word), q (delayed word)
module fft_seq_delay_line import fft_pkg::*; #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk or posedge areset)
    if (areset) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/fft_butterfly_sequencer.sv
// fft_butterfly_sequencer: address/strobe sequencer for an in-place radix-2 DIT FFT
// Ports: clk, areset (async, active high), bus (master modport: start in; busy, done,
//   rd_en, rd_addr_a/b, tw_addr, wr_en, wr_addr_a/b, stage out)
// Option FFT_SEQ_INVERSE_EN: bus.inverse sampled with start, bus.tw_conj held for the run
module fft_butterfly_sequencer import fft_pkg::*; #(
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int MEM_RD_LATENCY = MEM_RD_LATENCY_DEF,
  parameter int CU_LATENCY = CU_LATENCY_DEF
) (
  input logic clk,
  input logic areset,
  fft_butterfly_sequencer_if.master bus
);
  localparam int TL = MEM_RD_LATENCY + CU_LATENCY;
  localparam int SW = $clog2(LOG2_N);
  localparam int DW = $clog2(TL) + 1;
  seq_state_e state, nxt;
  logic [LOG2_N-2:0] k;
  logic [SW-1:0] stage;
  logic [DW-1:0] dcnt;
  logic last_d, last_s, rd;
  logic [LOG2_N-1:0] kx, half, j, a, twf, ra, rb;
  logic [LOG2_N-2:0] tw;
  assign last_d = dcnt == DW'(TL - 1);
  assign last_s = stage == SW'(LOG2_N - 1);
  always_ff @(posedge clk or posedge areset)
    if (areset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (bus.start ? ISSUE : IDLE) :
          state == ISSUE ? (&k ? DRAIN : ISSUE) :
          state == DRAIN ? (last_d ? (last_s ? DONE : ISSUE) : DRAIN) : IDLE;
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      k <= '0;
      stage <= '0;
      dcnt <= '0;
    end else begin
      k <= state == ISSUE ? k + (LOG2_N-1)'(1) : '0;
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      stage <= state == IDLE ? '0 : (state == DRAIN && last_d && !last_s) ? stage + SW'(1) : stage;
    end
  // Insert a zero at bit `stage` of k to get the top address; bottom is half above it.
  always_comb begin
    rd = state == ISSUE;
    kx = LOG2_N'(k);
    half = LOG2_N'(1) << stage;
    j = kx & (half - LOG2_N'(1));
    a = (((kx >> stage) << stage) << 1) | j;
    twf = j << (SW'(LOG2_N - 1) - stage);
    ra = rd ? a : '0;
    rb = rd ? a + half : '0;
    tw = rd ? twf[LOG2_N-2:0] : '0;
  end
  assign bus.rd_en = rd;
  assign bus.rd_addr_a = ra;
  assign bus.rd_addr_b = rb;
  assign bus.tw_addr = tw;
  assign bus.busy = state == ISSUE || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.stage = stage;
  fft_seq_delay_line #(.DEPTH(TL), .WIDTH(1 + 2*LOG2_N)) u_dly (
    .clk(clk),
    .areset(areset),
    .d({rd, ra, rb}),
    .q({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b})
  );
`ifdef FFT_SEQ_INVERSE_EN
  logic tc;
  always_ff @(posedge clk or posedge areset)
    if (areset) tc <= 1'b0;
    else if (state == IDLE && bus.start) tc <= bus.inverse;
    else if (state == DONE) tc <= 1'b0;
  assign bus.tw_conj = tc;
`endif
endmodule
